// File: rtl/limem_pkg.sv
// Shared opcode encoding and per-word control decode for the logic-in-memory bank.
// Hold is "OR with zero" (invert=1 keeps the OR plain), so an idle word never changes.
package limem_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_LOADN = 4'd2,
    OP_AND   = 4'd3,
    OP_NAND  = 4'd4,
    OP_OR    = 4'd5,
    OP_NOR   = 4'd6,
    OP_XOR   = 4'd7,
    OP_XNOR  = 4'd8,
    OP_READ  = 4'd9
  } op_e;

  typedef struct packed {
    logic do_force;
    logic do_invert;
    logic do_nand;
    logic do_nxor;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD = '{do_force: 1'b0, do_invert: 1'b1, do_nand: 1'b0, do_nxor: 1'b0};

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_READ);
  endfunction

  function automatic logic op_is_write(input op_e op);
    return (op >= OP_LOAD) && (op <= OP_XNOR);
  endfunction

  function automatic ctrl_t decode_op(input op_e op);
    ctrl_t c;
    case (op)
      OP_LOAD:  c = '{1'b1, 1'b0, 1'b0, 1'b0};
      OP_LOADN: c = '{1'b1, 1'b1, 1'b0, 1'b0};
      OP_AND:   c = '{1'b0, 1'b1, 1'b1, 1'b0};
      OP_NAND:  c = '{1'b0, 1'b0, 1'b1, 1'b0};
      OP_OR:    c = '{1'b0, 1'b1, 1'b0, 1'b0};
      OP_NOR:   c = '{1'b0, 1'b0, 1'b0, 1'b0};
      OP_XOR:   c = '{1'b0, 1'b1, 1'b0, 1'b1};
      OP_XNOR:  c = '{1'b0, 1'b0, 1'b0, 1'b1};
      default:  c = CTRL_HOLD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/limem_bank_ctrl_if.sv
// Command (valid/ready) and read-response (valid/ready) channels of the bank sequencer.
// cmd_op is kept as raw 4 bits so illegal codes can be carried and flagged.
interface limem_bank_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/limem_cmd_fifo.sv
// Small synchronous FIFO, DEPTH a power of two; head visible the cycle after push.
// Push while full is taken only if a pop happens in the same cycle.
module limem_cmd_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/limem_bank_ctrl.sv
// Sequencer for a DEPTH x WIDTH logic-in-memory bank: FIFO -> S1 register -> bank controls.
// Accept at edge t, bank commits at t+2; READs stall when the response slot is occupied.
module limem_bank_ctrl
  import limem_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  limem_bank_ctrl_if.slave       bus,
  output logic [DEPTH-1:0]       bank_force,
  output logic [DEPTH-1:0]       bank_invert,
  output logic [DEPTH-1:0]       bank_nand,
  output logic [DEPTH-1:0]       bank_nxor,
  output logic [DEPTH*WIDTH-1:0] bank_in,
  input  logic [DEPTH*WIDTH-1:0] bank_out,
  output logic                   busy,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = 4 + AW + WIDTH;

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_dout;
  logic [3:0]       head_op;
  logic [AW-1:0]    head_addr;
  logic [WIDTH-1:0] head_data;

  op_e              s1_op;
  logic [AW-1:0]    s1_addr;
  op_e              s1_op_nxt;
  logic [AW-1:0]    s1_addr_nxt;

  logic [DEPTH-1:0]       force_nxt;
  logic [DEPTH-1:0]       invert_nxt;
  logic [DEPTH-1:0]       nand_nxt;
  logic [DEPTH-1:0]       nxor_nxt;
  logic [DEPTH*WIDTH-1:0] in_nxt;
  ctrl_t                  head_ctrl;

  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_blocked;
  logic             s1_is_read;
  logic             s1_hold;
  logic             head_is_read;
  logic             stall;
  logic             head_ok;

  assign push          = bus.cmd_valid && !fifo_full;
  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  limem_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({bus.cmd_op, bus.cmd_addr, bus.cmd_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_op, head_addr, head_data} = fifo_dout;

  // A READ already in S1 is held too, otherwise it would overwrite an unconsumed response.
  assign rsp_blocked  = rsp_valid_q && !bus.rsp_ready;
  assign s1_is_read   = (s1_op == OP_READ);
  assign s1_hold      = s1_is_read && rsp_blocked;
  assign head_is_read = (head_op == 4'(OP_READ));
  assign stall        = rsp_blocked && (s1_is_read || head_is_read);
  assign pop          = !fifo_empty && !stall;
  assign head_ok      = op_legal(head_op) && ({1'b0, head_addr} < (AW+1)'(DEPTH));

  always_comb begin
    force_nxt   = '0;
    invert_nxt  = '1;
    nand_nxt    = '0;
    nxor_nxt    = '0;
    in_nxt      = '0;
    s1_op_nxt   = OP_NOP;
    s1_addr_nxt = '0;
    head_ctrl   = decode_op(op_e'(head_op));
    if (s1_hold) begin
      s1_op_nxt   = s1_op;
      s1_addr_nxt = s1_addr;
    end else if (pop && head_ok) begin
      s1_op_nxt              = op_e'(head_op);
      s1_addr_nxt            = head_addr;
      force_nxt[head_addr]   = head_ctrl.do_force;
      invert_nxt[head_addr]  = head_ctrl.do_invert;
      nand_nxt[head_addr]    = head_ctrl.do_nand;
      nxor_nxt[head_addr]    = head_ctrl.do_nxor;
      if (op_is_write(op_e'(head_op)))
        in_nxt[int'(head_addr)*WIDTH +: WIDTH] = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op       <= OP_NOP;
      s1_addr     <= '0;
      bank_force  <= '0;
      bank_invert <= '1;
      bank_nand   <= '0;
      bank_nxor   <= '0;
      bank_in     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err         <= 1'b0;
    end else begin
      s1_op       <= s1_op_nxt;
      s1_addr     <= s1_addr_nxt;
      bank_force  <= force_nxt;
      bank_invert <= invert_nxt;
      bank_nand   <= nand_nxt;
      bank_nxor   <= nxor_nxt;
      bank_in     <= in_nxt;
      if (pop && !head_ok) err <= 1'b1;
      // Writes commit at the end of their S1 cycle, so a following READ sees them here.
      if (s1_is_read && !s1_hold) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= bank_out[int'(s1_addr)*WIDTH +: WIDTH];
      end else if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign busy = !fifo_empty || (s1_op != OP_NOP);

endmodule

// File: tb/tb_limem_bank_ctrl.sv
// Bench: a behavioural bank driven by the controls, a response scoreboard, and a DEPTH=3 instance.
module tb_limem_bank_ctrl;
  import limem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  limem_bank_ctrl_if #(.WIDTH(8), .DEPTH(4)) bus ();
  limem_bank_ctrl_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

  logic [3:0]  bank_force, bank_invert, bank_nand, bank_nxor;
  logic [31:0] bank_in;
  logic [31:0] bank_q = '0;
  logic        busy, err;
  logic [2:0]  force3, invert3, nand3, nxor3;
  logic [23:0] in3;
  logic [23:0] out3 = '0;
  logic        busy3, err3;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  limem_bank_ctrl #(.WIDTH(8), .DEPTH(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .bank_force(bank_force), .bank_invert(bank_invert), .bank_nand(bank_nand),
    .bank_nxor(bank_nxor), .bank_in(bank_in), .bank_out(bank_q),
    .busy(busy), .err(err)
  );

  limem_bank_ctrl #(.WIDTH(8), .DEPTH(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .bank_force(force3), .bank_invert(invert3), .bank_nand(nand3),
    .bank_nxor(nxor3), .bank_in(in3), .bank_out(out3),
    .busy(busy3), .err(err3)
  );

  // Behavioural logic-in-memory word, from the opcode table.
  function automatic logic [7:0] word_next(input logic [7:0] q, input logic f, input logic inv,
                                           input logic na, input logic nx, input logic [7:0] d);
    logic [7:0] b;
    if (f) return inv ? ~d : d;
    b = na ? (q & d) : (nx ? (q ^ d) : (q | d));
    return inv ? b : ~b;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      bank_q[i*8 +: 8] <= word_next(bank_q[i*8 +: 8], bank_force[i], bank_invert[i],
                                    bank_nand[i], bank_nxor[i], bank_in[i*8 +: 8]);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : rsp_mon
    logic [7:0] e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %h, expected no response", bus.rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_data", {24'h0, bus.rsp_data}, {24'h0, e});
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [1:0] addr, input logic [7:0] d,
                      input logic [7:0] exp);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = d;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (op == 4'(OP_READ)) sb.push_back(exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || bus.rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string nm);
    check({nm, "_ctl"}, {16'h0, bank_force, bank_invert, bank_nand, bank_nxor}, 32'h0000_0F00);
    check({nm, "_in"}, bank_in, 32'h0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'(OP_LOAD),  8'hF0, 8'hF0};
    vecs[1] = '{4'(OP_AND),   8'h3C, 8'h30};
    vecs[2] = '{4'(OP_XOR),   8'hFF, 8'hCF};
    vecs[3] = '{4'(OP_NOR),   8'h00, 8'h30};
    vecs[4] = '{4'(OP_LOADN), 8'h0F, 8'hF0};
    vecs[5] = '{4'(OP_OR),    8'h0C, 8'hFC};
    vecs[6] = '{4'(OP_NAND),  8'hFF, 8'h03};
    vecs[7] = '{4'(OP_XNOR),  8'h05, 8'hF9};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b1;
    bus3.cmd_valid = 1'b0; bus3.cmd_op = '0; bus3.cmd_addr = '0; bus3.cmd_data = '0;
    bus3.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_hold("rst_hold");

    // LOAD word2 and look at the controls during its S1 cycle.
    send(4'(OP_LOAD), 2'd2, 8'hA5, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("load_ctl", {16'h0, bank_force, bank_invert, bank_nand, bank_nxor}, 32'h0000_4B00);
    check("load_in", bank_in, 32'h00A5_0000);
    @(posedge clk);
    #1;
    send(4'(OP_READ), 2'd2, 8'h00, 8'hA5);
    drain();

    // Every operation on word1, each followed directly by a READ.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, 2'd1, vecs[i].data, 8'h00);
      send(4'(OP_READ), 2'd1, 8'h00, vecs[i].exp);
    end
    drain();

    // Response backpressure: second READ must wait, FIFO fills, then everything drains in order.
    bus.rsp_ready = 1'b0;
    fork
      begin
        send(4'(OP_LOAD), 2'd0, 8'h11, 8'h00);
        send(4'(OP_READ), 2'd0, 8'h00, 8'h11);
        send(4'(OP_LOAD), 2'd3, 8'h22, 8'h00);
        send(4'(OP_READ), 2'd3, 8'h00, 8'h22);
        send(4'(OP_LOAD), 2'd0, 8'h33, 8'h00);
        send(4'(OP_READ), 2'd0, 8'h00, 8'h33);
        send(4'(OP_XOR),  2'd3, 8'hFF, 8'h00);
        send(4'(OP_READ), 2'd3, 8'h00, 8'hDD);
      end
      begin
        repeat (12) @(negedge clk);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rsp_data", 32'(bus.rsp_data), 32'h11);
        check("bp_busy", 32'(busy), 32'd1);
        check_hold("bp_hold");
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Illegal opcode: dropped, err sticks.
    send(4'hC, 2'd0, 8'hFF, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check_hold("illop_hold");
    check("illop_err", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    send(4'(OP_LOAD), 2'd0, 8'h5A, 8'h00);
    send(4'(OP_READ), 2'd0, 8'h00, 8'h5A);
    drain();
    check("err_sticky", 32'(err), 32'd1);

    // Reset with a held READ in flight and three LOADs queued.
    bus.rsp_ready = 1'b0;
    send(4'(OP_READ), 2'd0, 8'h00, 8'h5A);
    send(4'(OP_READ), 2'd0, 8'h00, 8'h5A);
    send(4'(OP_LOAD), 2'd1, 8'h77, 8'h00);
    send(4'(OP_LOAD), 2'd1, 8'h77, 8'h00);
    send(4'(OP_LOAD), 2'd1, 8'h77, 8'h00);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_hold("arst_hold");
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_hold("post_rst_hold");
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    send(4'(OP_READ), 2'd1, 8'h00, 8'hF9);
    drain();

    // DEPTH=3 build: address 3 is out of range.
    check("d3_err_clear", 32'(err3), 32'd0);
    check("d3_cmd_ready", 32'(bus3.cmd_ready), 32'd1);
    bus3.cmd_valid = 1'b1; bus3.cmd_op = 4'(OP_LOAD); bus3.cmd_addr = 2'd3; bus3.cmd_data = 8'h5A;
    @(posedge clk);
    #1;
    bus3.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("d3_drop_ctl", {20'h0, force3, invert3, nand3, nxor3}, 32'h0000_01C0);
      check("d3_drop_in", {8'h0, in3}, 32'h0);
    end
    check("d3_err", 32'(err3), 32'd1);
    @(posedge clk);
    #1;
    bus3.cmd_valid = 1'b1; bus3.cmd_addr = 2'd2; bus3.cmd_data = 8'h3C;
    @(posedge clk);
    #1;
    bus3.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("d3_load_ctl", {26'h0, force3, invert3}, 32'h0000_0023);
    check("d3_load_in", {8'h0, in3}, 32'h003C_0000);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
